// File: rtl/kara_col_accumulator_if.sv
// Product-in / word-out stream bundle for the Karatsuba column accumulator.
// The master side feeds products and consumes result words; the slave side is the accumulator.
interface kara_col_accumulator_if #(
  parameter int P_W   = 77,
  parameter int OUT_W = 34
);
  logic             in_valid;
  logic             in_ready;
  logic [P_W-1:0]   in_prod;
  logic             in_col_last;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_word;
  logic             out_last;

  modport master (
    output in_valid, in_prod, in_col_last, in_last, out_ready,
    input  in_ready, out_valid, out_word, out_last
  );

  modport slave (
    input  in_valid, in_prod, in_col_last, in_last, out_ready,
    output in_ready, out_valid, out_word, out_last
  );
endinterface

// File: rtl/kara_col_accumulator.sv
// Product-scanning column accumulator: sums products per column, emits OUT_W-bit words, flushes the tail.
// Optional macro KARA_ACC_OVF_EN enables sticky detection of accumulator carry-out on ovf.
module kara_col_accumulator #(
  parameter int P_W         = 77,
  parameter int ACC_W       = 86,
  parameter int OUT_W       = 34,
  parameter int FLUSH_WORDS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  kara_col_accumulator_if.slave bus,
  output logic                  ovf
);

  localparam int CNT_W = (FLUSH_WORDS > 1) ? $clog2(FLUSH_WORDS) : 1;

  typedef enum logic {
    ACC,
    FLUSH
  } state_t;

  state_t             state, state_n;
  logic [ACC_W-1:0]   acc, acc_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               out_valid_q, out_valid_n;
  logic [OUT_W-1:0]   out_word_q, out_word_n;
  logic               out_last_q, out_last_n;
  logic [ACC_W-1:0]   sum;
  logic               out_pending;
  logic               accept;
  logic               col_end;

  assign out_pending  = out_valid_q && !bus.out_ready;
  assign bus.in_ready = (state == ACC) && !out_pending;
  assign accept       = bus.in_valid && bus.in_ready;
  assign col_end      = bus.in_col_last || bus.in_last;

  assign bus.out_valid = out_valid_q;
  assign bus.out_word  = out_word_q;
  assign bus.out_last  = out_last_q;

`ifdef KARA_ACC_OVF_EN
  logic [ACC_W:0] sum_full;
  logic           carry;
  logic           ovf_q;

  assign sum_full = {1'b0, acc} + {{(ACC_W + 1 - P_W){1'b0}}, bus.in_prod};
  assign sum      = sum_full[ACC_W-1:0];
  assign carry    = sum_full[ACC_W];
  assign ovf      = ovf_q;

  // Sticky: only reset clears it; the sum itself still wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (accept && carry) begin
      ovf_q <= 1'b1;
    end
  end
`else
  assign sum = acc + {{(ACC_W - P_W){1'b0}}, bus.in_prod};
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ACC;
      acc         <= '0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state       <= state_n;
      acc         <= acc_n;
      cnt         <= cnt_n;
      out_valid_q <= out_valid_n;
      out_word_q  <= out_word_n;
      out_last_q  <= out_last_n;
    end
  end

  // A drained word clears out_valid unless a new word is loaded in the same cycle.
  always_comb begin
    state_n     = state;
    acc_n       = acc;
    cnt_n       = cnt;
    out_valid_n = out_valid_q && !bus.out_ready;
    out_word_n  = out_word_q;
    out_last_n  = out_last_q;

    case (state)
      ACC: begin
        if (accept) begin
          if (!col_end) begin
            acc_n = sum;
          end else begin
            out_word_n  = sum[OUT_W-1:0];
            out_valid_n = 1'b1;
            out_last_n  = 1'b0;
            acc_n       = sum >> OUT_W;
            if (bus.in_last) begin
              state_n = FLUSH;
              cnt_n   = '0;
            end
          end
        end
      end
      FLUSH: begin
        if (!out_pending) begin
          out_word_n  = acc[OUT_W-1:0];
          acc_n       = acc >> OUT_W;
          out_valid_n = 1'b1;
          cnt_n       = cnt + 1'b1;
          out_last_n  = (cnt == CNT_W'(FLUSH_WORDS - 1));
          if (cnt == CNT_W'(FLUSH_WORDS - 1)) begin
            acc_n   = '0;
            cnt_n   = '0;
            state_n = ACC;
          end
        end
      end
      default: begin
        state_n = ACC;
      end
    endcase
  end

endmodule

// File: tb/tb_kara_col_accumulator.sv
// Scoreboard bench for kara_col_accumulator: directed beats push expected words, a monitor pops and compares.
module tb_kara_col_accumulator;

  localparam int P_W   = 77;
  localparam int OUT_W = 34;

  typedef struct packed {
    logic [OUT_W-1:0] word;
    logic             last;
  } exp_t;

  logic clk;
  logic rst;
  logic ovf;
  int   checks;
  int   errors;
  int   wait_cycles;
  exp_t exp_q[$];

  kara_col_accumulator_if #(.P_W(P_W), .OUT_W(OUT_W)) bus ();

  kara_col_accumulator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .ovf (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor samples just before each rising edge, where a transfer is decided.
  always begin
    exp_t e;
    @(negedge clk);
    #4;
    if (!rst && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_word: got word=%h last=%b, none expected", bus.out_word, bus.out_last);
      end else begin
        e = exp_q.pop_front();
        if (bus.out_word !== e.word || bus.out_last !== e.last) begin
          errors++;
          $display("[TB] FAIL out_word: got word=%h last=%b, expected word=%h last=%b",
                   bus.out_word, bus.out_last, e.word, e.last);
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic expect_word(input logic [OUT_W-1:0] w, input logic l);
    exp_t e;
    e.word = w;
    e.last = l;
    exp_q.push_back(e);
  endtask

  // Called at a falling edge; returns at the falling edge after the beat was taken.
  task automatic apply_stimulus(input logic [P_W-1:0] prod, input logic col_last, input logic last);
    bus.in_valid    = 1'b1;
    bus.in_prod     = prod;
    bus.in_col_last = col_last;
    bus.in_last     = last;
    wait_cycles     = 0;
    #1;
    while (!bus.in_ready && wait_cycles < 20) begin
      @(negedge clk);
      #1;
      wait_cycles++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL in_ready_timeout: got in_ready=0, expected 1 within 20 cycles");
    end
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid    = 1'b0;
    bus.in_col_last = 1'b0;
    bus.in_last     = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d words outstanding, expected 0", exp_q.size());
    end
  endtask

  logic [P_W-1:0] ones;
  logic           exp_ovf;

  initial begin
    ones = '1;
`ifdef KARA_ACC_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_prod   = '0;
    idle();
    repeat (2) @(negedge clk);
    check_output("rst_out_valid", 34'(bus.out_valid), 34'd0);
    check_output("rst_out_word", bus.out_word, 34'd0);
    check_output("rst_out_last", 34'(bus.out_last), 34'd0);
    check_output("rst_ovf", 34'(ovf), 34'd0);
    rst = 1'b0;
    #1;
    check_output("rst_in_ready", 34'(bus.in_ready), 34'd1);
    @(negedge clk);

    // Single-beat column with last: column word plus two flush words.
    expect_word(34'h1_6789_ABCD, 1'b0);
    expect_word(34'h0_0000_48D1, 1'b0);
    expect_word(34'h0, 1'b1);
    apply_stimulus(77'h1_2345_6789_ABCD, 1'b1, 1'b1);
    idle();
    drain();
    #1;
    check_output("in_ready_after_flush", 34'(bus.in_ready), 34'd1);
    @(negedge clk);

    // Three beats of 2^76 in one column.
    expect_word(34'h0, 1'b0);
    expect_word(34'h0, 1'b0);
    expect_word(34'h300, 1'b1);
    apply_stimulus(77'd1 << 76, 1'b0, 1'b0);
    apply_stimulus(77'd1 << 76, 1'b0, 1'b0);
    apply_stimulus(77'd1 << 76, 1'b1, 1'b1);
    idle();
    drain();

    // Backpressure holds the word and blocks input.
    bus.out_ready = 1'b0;
    expect_word(34'd7, 1'b0);
    apply_stimulus(77'd7, 1'b1, 1'b0);
    idle();
    for (int i = 0; i < 5; i++) begin
      #1;
      check_output("bp_in_ready", 34'(bus.in_ready), 34'd0);
      check_output("bp_out_word", bus.out_word, 34'd7);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    expect_word(34'd9, 1'b0);
    expect_word(34'd0, 1'b0);
    expect_word(34'd0, 1'b1);
    apply_stimulus(77'd9, 1'b1, 1'b1);
    check_output("bp_release_wait", 34'(wait_cycles), 34'd0);
    idle();
    drain();

    // Full throughput: eight single-beat columns back to back.
    for (int i = 0; i < 8; i++) begin
      expect_word(34'(i + 1), 1'b0);
      apply_stimulus(77'(i + 1), 1'b1, (i == 7));
      check_output("tp_no_stall", 34'(wait_cycles), 34'd0);
    end
    expect_word(34'd0, 1'b0);
    expect_word(34'd0, 1'b1);
    idle();
    drain();

    // Async reset after the first flush word.
    expect_word(34'd7, 1'b0);
    apply_stimulus((77'd6 << 34) | 77'd7, 1'b1, 1'b1);
    idle();
    @(negedge clk);
    #1;
    check_output("flush1_word", bus.out_word, 34'd6);
    rst = 1'b1;
    #1;
    check_output("rst_mid_out_valid", 34'(bus.out_valid), 34'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check_output("rst_mid_in_ready", 34'(bus.in_ready), 34'd1);
    @(negedge clk);
    expect_word(34'd5, 1'b0);
    expect_word(34'd0, 1'b0);
    expect_word(34'd0, 1'b1);
    apply_stimulus(77'd5, 1'b1, 1'b1);
    idle();
    drain();

    // 512 max products fit exactly; the 513th carries out of the accumulator.
    for (int i = 0; i < 512; i++) begin
      apply_stimulus(ones, 1'b0, 1'b0);
    end
    idle();
    #1;
    check_output("ovf_512", 34'(ovf), 34'd0);
    @(negedge clk);
    apply_stimulus(ones, 1'b0, 1'b0);
    idle();
    #1;
    check_output("ovf_513", 34'(ovf), 34'(exp_ovf));
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
